// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pkg
//  Description : Shared constants for seq_controller and the instruction decoder
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

    localparam logic [3:0] CLS_RESET = 4'd0;
    localparam logic [3:0] CLS_FETCH = 4'd1;
    localparam logic [3:0] CLS_MOV   = 4'd2;
    localparam logic [3:0] CLS_LD    = 4'd3;
    localparam logic [3:0] CLS_ST    = 4'd4;
    localparam logic [3:0] CLS_ALU   = 4'd5;
    localparam logic [3:0] CLS_JMP   = 4'd6;
    localparam logic [3:0] CLS_HALT  = 4'd7;
    localparam logic [3:0] CLS_FAULT = 4'd8;

    localparam int unsigned STEPS_FETCH  = 3;
    localparam int unsigned STEPS_MOV    = 1;
    localparam int unsigned STEPS_LD     = 5;
    localparam int unsigned STEPS_ST     = 5;
    localparam int unsigned STEPS_ALU    = 3;
    localparam int unsigned STEPS_JMP    = 3;
    localparam int unsigned STEPS_JMP_NT = 1;
    localparam int unsigned DECODE_STEP  = 2;

    localparam int unsigned MEM_STEP_FETCH = 1;
    localparam int unsigned MEM_STEP_LD    = 2;
    localparam int unsigned MEM_STEP_ST    = 3;
    localparam int unsigned MEM_STEP_JMP   = 1;

    localparam logic [7:0] OP_MOV_MASK  = 8'hF0, OP_MOV_VAL  = 8'h00;
    localparam logic [7:0] OP_LD_MASK   = 8'hFC, OP_LD_VAL   = 8'h80;
    localparam logic [7:0] OP_ST_MASK   = 8'hF3, OP_ST_VAL   = 8'hA0;
    localparam logic [7:0] OP_ALU0_MASK = 8'hF0, OP_ALU0_VAL = 8'h20;
    localparam logic [7:0] OP_ALU1_MASK = 8'hF8, OP_ALU1_VAL = 8'h30;
    localparam logic [7:0] OP_ALU2_MASK = 8'hFC, OP_ALU2_VAL = 8'h3C;
    localparam logic [7:0] OP_JMP_MASK  = 8'hFC, OP_JMP_VAL  = 8'h60;
    localparam logic [7:0] OP_HALT_MASK = 8'hFF, OP_HALT_VAL = 8'hFF;

    localparam logic [1:0] CC_ALWAYS = 2'd0;
    localparam logic [1:0] CC_Z      = 2'd1;
    localparam logic [1:0] CC_CY     = 2'd2;
    localparam logic [1:0] CC_S      = 2'd3;

    typedef struct packed {
        logic [3:0] cls;
        logic [1:0] cc;
        logic       legal;
    } dec_t;

    function automatic logic op_match(input logic [7:0] op, input logic [7:0] mask,
                                      input logic [7:0] val);
        return (op & mask) == val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_controller_if
//  Description : Instruction/flag/memory inputs and sequencing outputs
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_controller_if #(
    parameter int IW     = 8,
    parameter int STEP_W = 3
);
    logic [IW-1:0]     I;
    logic [2:0]        SZCy;
    logic              mem_ready;
    logic              run;
    logic [3:0]        cls;
    logic [STEP_W-1:0] step;
    logic              mem_req;
    logic              end_sq;
    logic              fault;
    logic              pause_cc;

    modport master (
        input  I, SZCy, mem_ready, run,
        output cls, step, mem_req, end_sq, fault, pause_cc
    );

    modport slave (
        output I, SZCy, mem_ready, run,
        input  cls, step, mem_req, end_sq, fault, pause_cc
    );
endinterface
`default_nettype wire

// File: rtl/seq_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seq_decode
//  Description : Combinational opcode to instruction-class decode with legality
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_decode
    import seq_pkg::*;
#(
    parameter int IW = 8
) (
    input  logic [IW-1:0] i_instr,
    output dec_t          o_dec
);
    logic [7:0] w_op;
    logic       w_upper_zero;

    assign w_op = i_instr[7:0];

    generate
        if (IW > 8) begin : g_upper
            assign w_upper_zero = ~|i_instr[IW-1:8];
        end else begin : g_no_upper
            assign w_upper_zero = 1'b1;
        end
    endgenerate

    always_comb begin
        o_dec.cc    = w_op[1:0];
        o_dec.legal = 1'b0;
        o_dec.cls   = CLS_FAULT;
        if (w_upper_zero) begin
            o_dec.legal = 1'b1;
            if (op_match(w_op, OP_MOV_MASK, OP_MOV_VAL))        o_dec.cls = CLS_MOV;
            else if (op_match(w_op, OP_LD_MASK, OP_LD_VAL))     o_dec.cls = CLS_LD;
            else if (op_match(w_op, OP_ST_MASK, OP_ST_VAL))     o_dec.cls = CLS_ST;
            else if (op_match(w_op, OP_ALU0_MASK, OP_ALU0_VAL) ||
                     op_match(w_op, OP_ALU1_MASK, OP_ALU1_VAL) ||
                     op_match(w_op, OP_ALU2_MASK, OP_ALU2_VAL)) o_dec.cls = CLS_ALU;
            else if (op_match(w_op, OP_JMP_MASK, OP_JMP_VAL))   o_dec.cls = CLS_JMP;
            else if (op_match(w_op, OP_HALT_MASK, OP_HALT_VAL)) o_dec.cls = CLS_HALT;
            else                                                 o_dec.legal = 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: rtl/seq_controller.sv
`default_nettype none
// ============================================================================
//  Module      : seq_controller
//  Description : Moore micro-sequencer tracking class + step, falling-edge state
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_controller
    import seq_pkg::*;
#(
    parameter int IW       = 8,
    parameter int STEP_W   = 3,
    parameter int WAIT_MAX = 15
) (
    input  logic             clock,
    input  logic             reset_n,
    seq_controller_if.master bus
);
    localparam int                WCNT_W     = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WCNT_W-1:0] C_WAIT_MAX = WCNT_W'(WAIT_MAX);

    logic [3:0]        cls_q,  cls_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [WCNT_W-1:0] wait_q, wait_d;
    logic [1:0]        cc_q,   cc_d;

    dec_t              w_dec;
    logic [STEP_W-1:0] w_last;
    logic              w_mem_step;
    logic              w_taken;
    logic              w_timeout;
    logic              w_end;

    seq_decode #(.IW(IW)) u_decode (
        .i_instr (bus.I),
        .o_dec   (w_dec)
    );

    always_comb begin
        w_last     = '0;
        w_mem_step = 1'b0;
        case (cls_q)
            CLS_FETCH: begin
                w_last     = STEP_W'(STEPS_FETCH - 1);
                w_mem_step = (step_q == STEP_W'(MEM_STEP_FETCH));
            end
            CLS_MOV: w_last = STEP_W'(STEPS_MOV - 1);
            CLS_LD: begin
                w_last     = STEP_W'(STEPS_LD - 1);
                w_mem_step = (step_q == STEP_W'(MEM_STEP_LD));
            end
            CLS_ST: begin
                w_last     = STEP_W'(STEPS_ST - 1);
                w_mem_step = (step_q == STEP_W'(MEM_STEP_ST));
            end
            CLS_ALU: w_last = STEP_W'(STEPS_ALU - 1);
            CLS_JMP: begin
                w_last     = STEP_W'(STEPS_JMP - 1);
                w_mem_step = (step_q == STEP_W'(MEM_STEP_JMP));
            end
            default: ;
        endcase
    end

    always_comb begin
        case (cc_q)
            CC_ALWAYS: w_taken = 1'b1;
            CC_Z:      w_taken = bus.SZCy[1];
            CC_CY:     w_taken = bus.SZCy[0];
            CC_S:      w_taken = bus.SZCy[2];
            default:   w_taken = 1'b0;
        endcase
    end

    // Ready on the timeout edge still completes the access.
    assign w_timeout = (WAIT_MAX != 0) && (wait_q == C_WAIT_MAX);

    always_comb begin
        cls_d  = cls_q;
        step_d = step_q;
        wait_d = '0;
        cc_d   = cc_q;
        case (cls_q)
            CLS_RESET: begin
                cls_d  = CLS_FETCH;
                step_d = '0;
            end
            CLS_HALT, CLS_FAULT: ;
            CLS_FETCH, CLS_MOV, CLS_LD, CLS_ST, CLS_ALU, CLS_JMP: begin
                if (w_mem_step && !bus.mem_ready) begin
                    if (w_timeout) begin
                        cls_d  = CLS_FAULT;
                        step_d = '0;
                    end else begin
                        wait_d = (WAIT_MAX != 0) ? wait_q + WCNT_W'(1) : wait_q;
                    end
                end else if (cls_q == CLS_FETCH && step_q == '0 && !bus.run) begin
                    step_d = step_q;
                end else if (cls_q == CLS_FETCH && step_q == STEP_W'(DECODE_STEP)) begin
                    cls_d  = w_dec.legal ? w_dec.cls : CLS_FAULT;
                    cc_d   = w_dec.cc;
                    step_d = '0;
                end else if ((cls_q == CLS_JMP && step_q == STEP_W'(STEPS_JMP_NT - 1) && !w_taken)
                             || step_q == w_last) begin
                    cls_d  = CLS_FETCH;
                    step_d = '0;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            default: begin
                cls_d  = CLS_FAULT;
                step_d = '0;
            end
        endcase
    end

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cls_q  <= CLS_RESET;
            step_q <= '0;
            wait_q <= '0;
            cc_q   <= CC_ALWAYS;
        end else begin
            cls_q  <= cls_d;
            step_q <= step_d;
            wait_q <= wait_d;
            cc_q   <= cc_d;
        end
    end

    assign w_end        = (cls_q == CLS_HALT) || (cls_q == CLS_FAULT);
    assign bus.cls      = cls_q;
    assign bus.step     = step_q;
    assign bus.mem_req  = w_mem_step;
    assign bus.end_sq   = w_end;
    assign bus.fault    = (cls_q == CLS_FAULT);
    assign bus.pause_cc = (w_mem_step && !bus.mem_ready)
                        || (cls_q == CLS_FETCH && step_q == '0 && !bus.run)
                        || w_end;
endmodule
`default_nettype wire

// File: tb/tb_seq_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_controller
//  Description : Directed self-checking bench for seq_controller
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_controller;
    import seq_pkg::*;

    logic clock;
    logic reset_n;
    int   vecs;
    int   errs;

    seq_controller_if #(.IW(8), .STEP_W(3)) bus ();

    seq_controller #(.IW(8), .STEP_W(3), .WAIT_MAX(15)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    always #5 clock = ~clock;

    // State settles on the falling edge; observe and drive 2 time units later.
    task automatic ed();
        @(negedge clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic st(input string tag, input logic [3:0] c, input logic [2:0] s);
        chk({tag, ".cls"}, 32'(bus.cls), 32'(c));
        chk({tag, ".step"}, 32'(bus.step), 32'(s));
    endtask

    task automatic fl(input string tag, input logic mr, input logic es, input logic f,
                      input logic pc);
        chk({tag, ".mem_req"}, 32'(bus.mem_req), 32'(mr));
        chk({tag, ".end_sq"}, 32'(bus.end_sq), 32'(es));
        chk({tag, ".fault"}, 32'(bus.fault), 32'(f));
        chk({tag, ".pause_cc"}, 32'(bus.pause_cc), 32'(pc));
    endtask

    initial begin
        vecs          = 0;
        errs          = 0;
        clock         = 1'b0;
        reset_n       = 1'b0;
        bus.I         = 8'h06;
        bus.SZCy      = 3'b000;
        bus.mem_ready = 1'b1;
        bus.run       = 1'b1;

        // Reset and MOV
        ed();
        st("rst", CLS_RESET, 3'd0);
        fl("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        ed(); st("mov.f0", CLS_FETCH, 3'd0); fl("mov.f0", 1'b0, 1'b0, 1'b0, 1'b0);
        ed(); st("mov.f1", CLS_FETCH, 3'd1); fl("mov.f1", 1'b1, 1'b0, 1'b0, 1'b0);
        ed(); st("mov.f2", CLS_FETCH, 3'd2);
        ed(); st("mov.x0", CLS_MOV, 3'd0); fl("mov.x0", 1'b0, 1'b0, 1'b0, 1'b0);
        ed(); st("mov.end", CLS_FETCH, 3'd0);

        // JMP on Z, taken
        bus.I    = 8'h61;
        bus.SZCy = 3'b010;
        ed(); ed(); st("jt.f2", CLS_FETCH, 3'd2);
        ed(); st("jt.j0", CLS_JMP, 3'd0);
        ed(); st("jt.j1", CLS_JMP, 3'd1); fl("jt.j1", 1'b1, 1'b0, 1'b0, 1'b0);
        ed(); st("jt.j2", CLS_JMP, 3'd2);
        ed(); st("jt.end", CLS_FETCH, 3'd0);

        // JMP on Z, not taken
        bus.SZCy = 3'b000;
        ed(); ed(); ed(); st("jn.j0", CLS_JMP, 3'd0);
        ed(); st("jn.end", CLS_FETCH, 3'd0);

        // LD with three wait cycles at step 2
        bus.I = 8'h81;
        ed(); ed(); ed(); st("ld.l0", CLS_LD, 3'd0);
        ed(); st("ld.l1", CLS_LD, 3'd1);
        ed(); st("ld.l2", CLS_LD, 3'd2);
        bus.mem_ready = 1'b0;
        #1 fl("ld.stall", 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            ed(); st("ld.wait", CLS_LD, 3'd2);
            chk("ld.wait.pause", 32'(bus.pause_cc), 32'd1);
        end
        bus.mem_ready = 1'b1;
        #1 chk("ld.ready.pause", 32'(bus.pause_cc), 32'd0);
        ed(); st("ld.l3", CLS_LD, 3'd3);
        ed(); st("ld.l4", CLS_LD, 3'd4);
        ed(); st("ld.end", CLS_FETCH, 3'd0);

        // Timeout in FETCH step 1: 15 stalled edges survive, the 16th faults
        bus.I = 8'h06;
        ed(); st("to.f1", CLS_FETCH, 3'd1);
        bus.mem_ready = 1'b0;
        for (int k = 0; k < 15; k++) begin
            ed(); st("to.wait", CLS_FETCH, 3'd1);
        end
        ed(); st("to.fault", CLS_FAULT, 3'd0); fl("to.fault", 1'b0, 1'b1, 1'b1, 1'b1);
        ed(); st("to.hold", CLS_FAULT, 3'd0);
        reset_n = 1'b0;
        #1 st("to.rst", CLS_RESET, 3'd0); fl("to.rst", 1'b0, 1'b0, 1'b0, 1'b0);
        bus.mem_ready = 1'b1;
        reset_n       = 1'b1;
        ed(); st("to.f0", CLS_FETCH, 3'd0);

        // Ready arrives on the timeout edge: access completes
        ed(); st("tr.f1", CLS_FETCH, 3'd1);
        bus.mem_ready = 1'b0;
        for (int k = 0; k < 15; k++) ed();
        st("tr.wait15", CLS_FETCH, 3'd1);
        bus.mem_ready = 1'b1;
        ed(); st("tr.f2", CLS_FETCH, 3'd2); fl("tr.f2", 1'b0, 1'b0, 1'b0, 1'b0);
        ed(); st("tr.mov", CLS_MOV, 3'd0);
        ed(); st("tr.end", CLS_FETCH, 3'd0);

        // Illegal 0011_10xx
        bus.I = 8'h38;
        ed(); ed(); ed(); st("ill", CLS_FAULT, 3'd0); fl("ill", 1'b0, 1'b1, 1'b1, 1'b1);
        reset_n = 1'b0;
        #1 st("ill.rst", CLS_RESET, 3'd0);
        reset_n = 1'b1;
        ed(); st("ill.f0", CLS_FETCH, 3'd0);

        // HALT is absorbing, reset exits asynchronously
        bus.I = 8'hFF;
        ed(); ed(); ed(); st("halt", CLS_HALT, 3'd0); fl("halt", 1'b0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 20; k++) begin
            ed(); st("halt.hold", CLS_HALT, 3'd0);
        end
        reset_n = 1'b0;
        #1 st("halt.rst", CLS_RESET, 3'd0); fl("halt.rst", 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        ed(); st("halt.f0", CLS_FETCH, 3'd0);

        // run gating at FETCH step 0
        bus.I   = 8'h3C;
        bus.run = 1'b0;
        #1 chk("run.pause", 32'(bus.pause_cc), 32'd1);
        for (int k = 0; k < 5; k++) begin
            ed(); st("run.hold", CLS_FETCH, 3'd0);
            chk("run.hold.pause", 32'(bus.pause_cc), 32'd1);
        end
        bus.run = 1'b1;
        #1 chk("run.go.pause", 32'(bus.pause_cc), 32'd0);
        ed(); st("run.f1", CLS_FETCH, 3'd1);

        // ALU 0011_11xx
        ed(); st("alu.f2", CLS_FETCH, 3'd2);
        ed(); st("alu.a0", CLS_ALU, 3'd0);
        ed(); st("alu.a1", CLS_ALU, 3'd1);
        ed(); st("alu.a2", CLS_ALU, 3'd2);
        ed(); st("alu.end", CLS_FETCH, 3'd0);

        // ST with memory access at step 3
        bus.I = 8'hA4;
        ed(); ed(); ed(); st("st.s0", CLS_ST, 3'd0);
        for (int s = 1; s < 5; s++) begin
            ed(); st("st.step", CLS_ST, 3'(s));
            chk("st.mem_req", 32'(bus.mem_req), (s == 3) ? 32'd1 : 32'd0);
        end
        ed(); st("st.end", CLS_FETCH, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/seq_controller.md
# seq_controller

Parametrised successor to the CPU's fixed-state controller. It is a Moore micro-sequencer that tracks each instruction as an instruction class plus a step counter, instead of one hard-coded state per step. New over the previous controller: memory wait states with a timeout fault, conditional jumps on SZCy, single-step run gating, and a separate FAULT state for illegal opcodes. It sits between the I register/flags and the instruction decoder, which turns {cls, step} into xsrc/xdst/aluop/we.

## Interface
- IW, 8, instruction width; decode uses I[7:0], upper bits must be 0 or the opcode is illegal
- STEP_W, 3, step counter width; must be ≥3
- WAIT_MAX, 15, maximum wait cycles per memory step; 0 disables the timeout
- clock  in  1  system clock; all state updates on the falling edge, same as the existing controller
- reset_n  in  1  asynchronous, active-low reset
- I  in  IW  instruction register
- SZCy  in  3  flags: [2]=S, [1]=Z, [0]=Cy
- mem_ready  in  1  memory completes the current access this cycle
- run  in  1  permits a new fetch
- cls  out  4  current instruction class (package constant)
- step  out  STEP_W  step within the class
- mem_req  out  1  current step is a memory step
- end_sq  out  1  high in HALT or FAULT
- fault  out  1  high in FAULT
- pause_cc  out  1  cycle counter hold

## Operation
- Classes: RESET=0, FETCH=1, MOV=2, LD=3, ST=4, ALU=5, JMP=6, HALT=7, FAULT=8.
- Step count per class: FETCH 3, MOV 1, LD 5, ST 5, ALU 3, JMP 3 if taken / 1 if not taken.
- Memory steps: FETCH 1, LD 2, ST 3, JMP 1.
- Decode happens at FETCH step 2. I[7:0] is matched with priority:
  - 0000_xxxx → MOV
  - 1000_00xx → LD
  - 1010_xx00 → ST
  - 0010_xxxx, 0011_0xxx, 0011_11xx → ALU
  - 0110_00cc → JMP
  - 1111_1111 → HALT
  - anything else (including 0011_10xx) → FAULT
- The class and cc are latched at decode. I is not re-examined after that.
- JMP condition: cc=00 always, 01 Z, 10 Cy, 11 S. SZCy is sampled at JMP step 0. If not taken, the next state is FETCH step 0 (the decoder increments PC in that step).
- On the last step of any class, go to FETCH step 0.
- run gating: on entry to FETCH step 0, stay there while run=0.
- Memory wait and timeout:
  - In a memory step, step does not advance while mem_ready=0. A wait counter counts these stalled cycles.
  - The counter clears on entering each memory step.
  - If mem_ready=0 when the counter equals WAIT_MAX (WAIT_MAX≠0), go to FAULT.
  - If mem_ready=1 on that same edge, the access completes and the machine advances; ready wins over timeout.
- HALT and FAULT are absorbing. Only reset_n exits them.
- Outputs:
  - mem_req = memory step
  - pause_cc = (stalled on mem_ready=0) | (FETCH step 0 with run=0) | HALT | FAULT
  - end_sq = HALT | FAULT
- All outputs are decoded from state registers only (Moore), except that pause_cc includes the current mem_ready and run.

## Timing
- While reset_n=0: cls=RESET, step=0, wait counter=0, mem_req=0, end_sq=0, fault=0, pause_cc=0.
- First falling edge after release: FETCH step 0.
- Asserting reset_n mid-instruction (including during a wait) aborts immediately. No memory or flag state is held.
- Zero-wait instruction latency in falling edges, FETCH included: MOV 4, ALU 6, LD 8, ST 8, JMP taken 6, not taken 4.
- Each wait cycle adds one edge.
- step wraps to 0 only via class change; it never overflows within a class.

## Structure
- Shared package seq_pkg holds:
  - class constants (CLS_*)
  - per-class step counts
  - memory-step positions
  - opcode match masks
  - cc encodings
- The instruction decoder imports the same package.
- One sub-module, seq_decode: combinational I → class plus legality check, instantiated once.
- Wait counter width is clog2(WAIT_MAX+1), minimum 1.

## Test plan
- Reset, then I=0000_0110 (MOV), mem_ready=1, run=1 → cls sequence RESET, FETCH 0/1/2, MOV 0, FETCH 0; end_sq=0 throughout.
- I=0110_0001 with SZCy=010 → JMP steps 0, 1, 2 then FETCH. With SZCy=000 → JMP step 0 then FETCH.
- LD (I=1000_0001) with mem_ready low for 3 cycles at step 2 → step held at 2 for 3 extra edges with pause_cc=1, then steps 3, 4, FETCH.
- WAIT_MAX=15 with mem_ready held 0 in FETCH step 1 → FAULT after 16 edges; fault=1, end_sq=1, pause_cc=1. Variant: mem_ready=1 on the timeout edge → advances, no fault.
- I=0011_1000 → FAULT. I=1111_1111 → HALT, held there for 20 edges; reset_n low → RESET asynchronously.
- run=0 at FETCH step 0 for 5 edges → state held with pause_cc=1; run=1 → FETCH step 1 on the next edge.
